// File: rtl/sext_pipe.sv
// Two-stage valid/ready immediate extractor for the LC-3 datapath.
// Stage 1 captures the masked IR field and mode bits; stage 2 extends, optionally shifts, and flags the result.
module sext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  ir,
  input  logic [1:0]       sel,
  input  logic             zext,
  input  logic             shl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg,
  output logic             out_zero,
  output logic [15:0]      xfer_cnt
);

  logic        s1_valid;
  logic [10:0] s1_field;
  logic [1:0]  s1_sel;
  logic        s1_zext;
  logic        s1_shl;
  logic        s2_valid;

  logic        s1_load;
  logic        s2_load;
  logic [10:0] in_mask;

  logic [3:0]       fw;
  logic             sb;
  logic [OUT_W-1:0] low_mask;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] res;

  // IR bits above the widest field are never used.
  if (IN_W > 11) begin : g_unused_ir
    logic unused_ir_hi;
    assign unused_ir_hi = ^ir[IN_W-1:11];
  end

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  always_comb begin
    in_mask = 11'h7FF;
    case (sel)
      2'd0:    in_mask = 11'h01F;
      2'd1:    in_mask = 11'h03F;
      2'd2:    in_mask = 11'h1FF;
      default: in_mask = 11'h7FF;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_field <= '0;
      s1_sel   <= '0;
      s1_zext  <= 1'b0;
      s1_shl   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_field <= ir[10:0] & in_mask;
        s1_sel   <= sel;
        s1_zext  <= zext;
        s1_shl   <= shl;
      end
    end
  end

  // Field is already zero above its width, so extension only has to fill the upper bits.
  always_comb begin
    fw = 4'd11;
    sb = s1_field[10];
    case (s1_sel)
      2'd0:    begin fw = 4'd5;  sb = s1_field[4];  end
      2'd1:    begin fw = 4'd6;  sb = s1_field[5];  end
      2'd2:    begin fw = 4'd9;  sb = s1_field[8];  end
      default: begin fw = 4'd11; sb = s1_field[10]; end
    endcase
    low_mask = (OUT_W'(1) << fw) - OUT_W'(1);
    if (s1_zext || !sb) ext = OUT_W'(s1_field);
    else                ext = OUT_W'(s1_field) | ~low_mask;
    res = s1_shl ? {ext[OUT_W-2:0], 1'b0} : ext;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_neg  <= 1'b0;
      out_zero <= 1'b1;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res;
        out_neg  <= res[OUT_W-1];
        out_zero <= (res == '0);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                       xfer_cnt <= '0;
    else if (s2_valid && out_ready)  xfer_cnt <= xfer_cnt + 16'd1;
  end

endmodule
